// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: ALUOp encodings, R-type funct codes,
// the internal ALU-operation enum and the EX/MEM register layout.
package pipeline_pkg;

    localparam logic [1:0] ALUOP_ADD     = 2'b00;
    localparam logic [1:0] ALUOP_SUB     = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT   = 2'b10;
    localparam logic [1:0] ALUOP_ADD_ALT = 2'b11;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_NOR = 6'b100111;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_NOR,
        ALU_SLT
    } alu_op_e;

    typedef struct packed {
        logic [31:0] alu_result;
        logic        zero;
        logic [31:0] store_data;
        logic [4:0]  write_reg;
        logic [10:0] jump_dest;
        logic        mem_to_reg;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        valid;
        logic        illegal_op;
    } ex_mem_t;

endpackage

// File: rtl/alu_control.sv
// Maps ALUOp plus the R-type funct field onto an ALU operation; flags
// funct codes that have no meaning so the stage can squash side effects.
module alu_control
    import pipeline_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output alu_op_e    alu_sel,
    output logic       illegal
);

    always_comb begin
        alu_sel = ALU_ADD;
        illegal = 1'b0;
        case (alu_op)
            ALUOP_ADD, ALUOP_ADD_ALT: alu_sel = ALU_ADD;
            ALUOP_SUB:                alu_sel = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FUNCT_ADD: alu_sel = ALU_ADD;
                    FUNCT_SUB: alu_sel = ALU_SUB;
                    FUNCT_AND: alu_sel = ALU_AND;
                    FUNCT_OR:  alu_sel = ALU_OR;
                    FUNCT_NOR: alu_sel = ALU_NOR;
                    FUNCT_SLT: alu_sel = ALU_SLT;
                    default:   illegal = 1'b1;
                endcase
            end
            default: alu_sel = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/execute_stage.sv
// EX stage: operand select, ALU and the EX/MEM pipeline register.
// All outputs come straight from the EX/MEM register (one-cycle latency).
module execute_stage
    import pipeline_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_a,
    input  logic [31:0] data_b,
    input  logic [31:0] sign_extended,
    input  logic [10:0] jump_dest_addr,
    input  logic [4:0]  reg_dest_r_type,
    input  logic [4:0]  reg_dest_l_type,
    input  logic        RegDst,
    input  logic        ALUSrc,
    input  logic        MemToReg,
    input  logic        RegWrite,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        Branch,
    input  logic [1:0]  ALUOp,
    input  logic        valid_in,
    input  logic        stall,
    input  logic        flush,
    output logic [31:0] alu_result_out,
    output logic        zero_out,
    output logic [31:0] store_data_out,
    output logic [4:0]  write_reg_out,
    output logic [10:0] jump_dest_out,
    output logic        MemToReg_out,
    output logic        RegWrite_out,
    output logic        MemRead_out,
    output logic        MemWrite_out,
    output logic        Branch_out,
    output logic        valid_out,
    output logic        illegal_op_out
);

    alu_op_e     alu_sel;
    logic        illegal;
    logic [31:0] operand_b;
    logic [31:0] alu_result;
    ex_mem_t     ex_mem_d;
    ex_mem_t     ex_mem_q;

    alu_control u_alu_control (
        .alu_op  (ALUOp),
        .funct   (sign_extended[5:0]),
        .alu_sel (alu_sel),
        .illegal (illegal)
    );

    assign operand_b = ALUSrc ? sign_extended : data_b;

    // Add/sub wrap silently; an illegal funct forces the result to zero.
    always_comb begin
        alu_result = 32'd0;
        if (!illegal) begin
            case (alu_sel)
                ALU_ADD: alu_result = data_a + operand_b;
                ALU_SUB: alu_result = data_a - operand_b;
                ALU_AND: alu_result = data_a & operand_b;
                ALU_OR:  alu_result = data_a | operand_b;
                ALU_NOR: alu_result = ~(data_a | operand_b);
                ALU_SLT: alu_result = ($signed(data_a) < $signed(operand_b)) ? 32'd1 : 32'd0;
                default: alu_result = 32'd0;
            endcase
        end
    end

    always_comb begin
        ex_mem_d            = '0;
        ex_mem_d.alu_result = alu_result;
        ex_mem_d.zero       = (alu_result == 32'd0);
        ex_mem_d.store_data = data_b;
        ex_mem_d.write_reg  = RegDst ? reg_dest_r_type : reg_dest_l_type;
        ex_mem_d.jump_dest  = jump_dest_addr;
        ex_mem_d.mem_to_reg = MemToReg;
        ex_mem_d.reg_write  = RegWrite & ~illegal;
        ex_mem_d.mem_read   = MemRead  & ~illegal;
        ex_mem_d.mem_write  = MemWrite & ~illegal;
        ex_mem_d.branch     = Branch   & ~illegal;
        ex_mem_d.valid      = 1'b1;
        ex_mem_d.illegal_op = illegal;
    end

    // valid_in qualifies the ID/EX slot; stall holds EX/MEM, flush loads a
    // bubble and wins over stall; an invalid slot also loads a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_mem_q <= '0;
        end else if (flush) begin
            ex_mem_q <= '0;
        end else if (stall) begin
            ex_mem_q <= ex_mem_q;
        end else if (!valid_in) begin
            ex_mem_q <= '0;
        end else begin
            ex_mem_q <= ex_mem_d;
        end
    end

    assign alu_result_out = ex_mem_q.alu_result;
    assign zero_out       = ex_mem_q.zero;
    assign store_data_out = ex_mem_q.store_data;
    assign write_reg_out  = ex_mem_q.write_reg;
    assign jump_dest_out  = ex_mem_q.jump_dest;
    assign MemToReg_out   = ex_mem_q.mem_to_reg;
    assign RegWrite_out   = ex_mem_q.reg_write;
    assign MemRead_out    = ex_mem_q.mem_read;
    assign MemWrite_out   = ex_mem_q.mem_write;
    assign Branch_out     = ex_mem_q.branch;
    assign valid_out      = ex_mem_q.valid;
    assign illegal_op_out = ex_mem_q.illegal_op;

endmodule

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 The block SHALL have one clock and asynchronous, active-high reset: clock in 1 (rising edge); reset in 1 (async, active-high).
REQ-002 data_a, data_b in 32: ID/EX register operands.
REQ-003 sign_extended in 32: ID/EX immediate; bits [5:0] are funct.
REQ-004 jump_dest_addr in 11: branch target from decode.
REQ-005 reg_dest_r_type, reg_dest_l_type in 5: candidate write registers.
REQ-006 RegDst, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, Branch in 1 each; ALUOp in 2: control bits from ID/EX.
REQ-007 valid_in in 1: ID/EX slot holds a real instruction.
REQ-008 stall in 1: hold EX/MEM contents.
REQ-009 flush in 1: replace the next EX/MEM contents with a bubble.
REQ-010 alu_result_out out 32; zero_out out 1; store_data_out out 32; write_reg_out out 5; jump_dest_out out 11.
REQ-011 MemToReg_out, RegWrite_out, MemRead_out, MemWrite_out, Branch_out out 1 each; valid_out out 1; illegal_op_out out 1.

Function
REQ-012 operand_b SHALL be sign_extended when ALUSrc=1, else data_b.
REQ-013 ALUOp decode: 00 -> add (lw/sw); 01 -> sub (beq); 11 -> add; 10 -> decode by funct.
REQ-014 Funct decode: 100000 add; 100010 sub; 100100 and; 100101 or; 100111 nor; 101010 slt (signed); anything else -> illegal.
REQ-015 Add/sub SHALL wrap modulo 2^32 and raise no overflow flag; slt result SHALL be 32'd1 or 32'd0.
REQ-016 zero SHALL be 1 iff the 32-bit ALU result equals 0.
REQ-017 write_reg SHALL be reg_dest_r_type when RegDst=1, else reg_dest_l_type.
REQ-018 Illegal funct with valid_in=1: result 0; RegWrite, MemRead, MemWrite and Branch all registered as 0; illegal_op_out=1 for that slot.
REQ-019 All outputs SHALL be registered (EX/MEM register); latency is exactly 1 clock from inputs to outputs.
REQ-020 valid_in=0 SHALL register a bubble: valid_out=0 and all control outputs 0; data outputs are don't-care but SHALL be driven 0.
REQ-021 stall=1, flush=0: every output register SHALL hold its value.
REQ-022 flush=1 SHALL register a bubble regardless of stall or valid_in; flush takes priority over stall.
REQ-023 store_data_out SHALL equal data_b (not operand_b).
REQ-024 jump_dest_out SHALL pass jump_dest_addr through unchanged.
REQ-025 Branch resolution is downstream: Branch_out AND zero_out.

Reset
REQ-026 While reset=1, all output registers SHALL be 0 asynchronously, including valid_out and illegal_op_out.
REQ-027 Reset asserted mid-stall SHALL clear the held contents; the first edge after release SHALL capture the current inputs normally.

Structure
REQ-028 ALUOp encodings, funct codes and the internal ALU-operation enum SHALL live in the shared package pipeline_pkg.
REQ-029 One sub-module, alu_control (ALUOp + funct -> ALU operation + illegal flag), is natural; the ALU datapath and EX/MEM register stay in execute_stage.

Verification
REQ-030 R-type add: data_a=5, data_b=7, funct 100000, ALUOp=10, RegDst=1, rd=3 -> next edge: alu_result_out=12, write_reg_out=3, RegWrite_out=1, zero_out=0.
REQ-031 beq: data_a=data_b=0x1234, ALUOp=01, Branch=1, jump_dest_addr=0x040 -> zero_out=1, Branch_out=1, jump_dest_out=0x040.
REQ-032 lw: data_a=0x100, sign_extended=0xFFFFFFFC, ALUSrc=1, ALUOp=00 -> alu_result_out=0xFC, MemRead_out=1, write_reg_out=rt.
REQ-033 slt signed: data_a=0xFFFFFFFF, data_b=1 -> alu_result_out=1.
REQ-034 Stall then flush: stall=1 for 3 cycles -> outputs held; stall=1 and flush=1 -> valid_out=0 and all control outputs 0.
REQ-035 Illegal funct 111111 with RegWrite=1 -> illegal_op_out=1, RegWrite_out=0; async reset mid-stream -> all outputs 0 immediately, without waiting for a clock edge.
